// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from registered state; training is applied on the clock edge.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  input  logic        clr,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [29:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit;
  logic             tbl_we;
  logic             alloc;
  logic [1:0]       ctr_d;

  // PC[1:0] never participates in indexing, tagging or stored targets.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  always_comb begin
    pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = pred_hit && ctr_q[f_idx][1];
    pred_target = pred_hit ? {tgt_q[f_idx], 2'b00} : '0;
  end

  always_comb begin
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ctr_d  = ctr_q[u_idx];
    tbl_we = 1'b0;
    alloc  = 1'b0;
    if (upd_en && !clr) begin
      if (u_hit) begin
        tbl_we = 1'b1;
        if (upd_taken) ctr_d = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
        else           ctr_d = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
      end else if (upd_taken) begin
        tbl_we = 1'b1;
        alloc  = 1'b1;
        ctr_d  = 2'd2;
      end
    end
  end

  // Statistics count every strobe, including ones dropped from the table by clr.
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_en) begin
      br_count_d = br_count_q + 32'd1;
      if (upd_mispred) mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i[IDX_W-1:0]] <= 1'b0;
        tag_q[i[IDX_W-1:0]]   <= '0;
        tgt_q[i[IDX_W-1:0]]   <= '0;
        ctr_q[i[IDX_W-1:0]]   <= '0;
      end
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
      if (clr) begin
        for (int unsigned i = 0; i < ENTRIES; i++) valid_q[i[IDX_W-1:0]] <= 1'b0;
      end else if (tbl_we) begin
        ctr_q[u_idx] <= ctr_d;
        if (upd_taken) tgt_q[u_idx] <= upd_target[31:2];
        if (alloc) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
        end
      end
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting beside fetch and directly upstream of the hazard unit. It predicts taken/target for the instruction at the fetch PC; fetch redirects on a taken prediction, and that decision travels down the pipe as the hazard unit's `br_taken` input. The hazard unit resolves the branch and returns `br` / `br_result` / `braddr`, which train the table here.

## Interface
- `ENTRIES`, 16: table depth; power of two, 4..256. `IDX_W = log2(ENTRIES)`, `TAG_W = 30 - IDX_W`.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `fetch_pc`  in  32  PC being fetched.
- `pred_hit`  out  1  valid entry with matching tag at `fetch_pc`.
- `pred_taken`  out  1  `pred_hit && ctr[1]`.
- `pred_target`  out  32  stored target of the hit entry; 0 when `pred_hit` = 0.
- `upd_en`  in  1  a resolved branch is presented this cycle (driven from hazard unit `br`, already qualified by ihit).
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome (hazard unit `br_result`).
- `upd_target`  in  32  actual taken target.
- `upd_mispred`  in  1  hazard unit redirected fetch for this branch (PCSel = 3); only meaningful with `upd_en`.
- `clr`  in  1  synchronous invalidate of all entries.
- `br_count`  out  32  resolved branches since reset.
- `mispred_count`  out  32  mispredicted branches since reset.

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. PC[1:0] ignored.
- Entry: `valid`, `tag[TAG_W]`, `target[30]` (word address; bits 1:0 reconstructed as 0), `ctr[2]`.
- Lookup is purely combinational from registered table state; no bypass. A lookup and an update to the same index in the same cycle returns the pre-update contents.
- Update, when `upd_en` = 1 and `clr` = 0:
  - Hit, taken: `ctr` increments, saturating at 3; `target` <= `upd_target`.
  - Hit, not taken: `ctr` decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate (overwrite any occupant): valid = 1, tag, target, `ctr` = 2 (weakly taken).
  - Miss, not taken: table unchanged.
- `clr` = 1: all `valid` cleared next edge; a same-cycle update is dropped for the table but still counted in the statistics.
- Counters: `br_count` += 1 on each `upd_en`; `mispred_count` += 1 when `upd_en && upd_mispred`. Both wrap modulo 2^32. `upd_mispred` without `upd_en` is ignored.
- Trained counter values: 0 strongly not-taken, 1 weakly not-taken, 2 weakly taken, 3 strongly taken.

## Timing
- Reset (`RST` high at an edge): all `valid` = 0, all `ctr` = 0, tags and targets = 0, `br_count` = `mispred_count` = 0. Hence `pred_hit` = `pred_taken` = 0 and `pred_target` = 0 from the first edge after reset. `RST` overrides `clr` and `upd_en`.
- Reset mid-operation discards every pending and same-cycle update.
- Prediction latency: 0 cycles, combinational from `fetch_pc`.
- Update latency: 1 cycle. The edge that samples `upd_en` writes the entry, and the first lookup to observe it is in the following cycle. Counters are visible the cycle after that edge.
- No handshake. `upd_en` is a single-cycle strobe per resolved branch, and back-to-back strobes on consecutive cycles, including to the same index, each apply in order.
- Aliasing: two PCs sharing an index but with different tags evict each other only on a taken miss.

## Test plan
- Reset then lookup `fetch_pc` = 0x0000_0040 -> `pred_hit` = 0, `pred_taken` = 0, `pred_target` = 0, both counters 0.
- Update pc 0x40, taken, target 0x80, mispred = 1 -> next cycle lookup 0x40 gives hit = 1, taken = 1, target 0x80, `ctr` = 2; `br_count` = 1, `mispred_count` = 1.
- Same pc: two not-taken updates -> `ctr` goes 1, then 0, and `pred_taken` = 0 after the first. A third not-taken update keeps `ctr` = 0. Then three taken updates -> `ctr` goes 1, 2, 3, and a fourth keeps 3.
- With ENTRIES = 16: allocate 0x40 (taken), then taken update 0x80 (same index, different tag) -> lookup 0x40 misses and 0x80 hits. A not-taken update of 0x40 then leaves 0x80 intact.
- Not-taken update of a never-seen pc 0x100 -> no allocation, lookup misses; `br_count` increments and `mispred_count` is unchanged when `upd_mispred` = 0.
- `clr` asserted together with a taken update for 0x40 -> all lookups miss next cycle and `br_count` increments. Then assert `RST` with `upd_en` = 1 -> both counters 0 and the table stays empty.
